// File: rtl/cond_pkg.sv
// Shared constants for the input conditioner: board clock, debounce window
// for silicon, and a short window used when simulating.
package cond_pkg;

   localparam int CLK_FREQ_HZ             = 100000000;
   localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;   // 10 ms at CLK_FREQ_HZ
   localparam int SIM_DEBOUNCE_CYCLES     = 4;

endpackage

// File: rtl/debounce_bit.sv
// One conditioned input: 2-flop synchronizer, counter-based debounce, and
// registered edge pulses. The falling-edge pulse exists only when
// INPUT_CONDITIONER_FALL_EDGE_EN is defined; otherwise fall_out is tied low.
module debounce_bit
   import cond_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int CNT_WIDTH       = $clog2(DEBOUNCE_CYCLES)
) (
   input  logic clk,
   input  logic reset,
   input  logic raw_in,
   output logic level_out,
   output logic rise_out,
   output logic fall_out
);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

   logic                 r_sync1;
   logic                 r_sync2;
   logic [CNT_WIDTH-1:0] r_cnt;
   logic                 r_level;
   logic                 r_rise;
   logic                 w_differ;
   logic                 w_accept;

   // The synchronized value disagrees with the stable level; accept it once the
   // counter has seen DEBOUNCE_CYCLES-1 prior disagreeing cycles.
   assign w_differ = r_sync2 ^ r_level;
   assign w_accept = w_differ && (r_cnt == CNT_MAX);

   // Two-flop synchronizer for the asynchronous pin, nothing in between.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= raw_in;
         r_sync2 <= r_sync1;
      end
   end

   // Debounce counter, stable level and rising pulse; any agreeing cycle
   // restarts the count, and the counter clears instead of wrapping.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt   <= '0;
         r_level <= 1'b0;
         r_rise  <= 1'b0;
      end else begin
         r_rise <= w_accept & r_sync2;
         if (!w_differ) begin
            r_cnt <= '0;
         end else if (w_accept) begin
            r_level <= r_sync2;
            r_cnt   <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign level_out = r_level;
   assign rise_out  = r_rise;

`ifdef INPUT_CONDITIONER_FALL_EDGE_EN
   logic r_fall;

   // Falling pulse, timed like the rising pulse (same edge as the level change).
   always_ff @(posedge clk) begin
      if (reset) r_fall <= 1'b0;
      else       r_fall <= w_accept & ~r_sync2;
   end

   assign fall_out = r_fall;
`else
   assign fall_out = 1'b0;
`endif

endmodule

// File: rtl/input_conditioner.sv
// Conditions N_INPUTS raw switch/button pins into debounced levels plus
// single-cycle edge pulses, one independent debounce_bit per input.
// Optional falling-edge pulses: define INPUT_CONDITIONER_FALL_EDGE_EN.
module input_conditioner
   import cond_pkg::*;
#(
   parameter int N_INPUTS        = 4,
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [N_INPUTS-1:0] raw_in,
   output logic [N_INPUTS-1:0] level_out,
   output logic [N_INPUTS-1:0] rise_out,
   output logic [N_INPUTS-1:0] fall_out
);

   localparam int CNT_WIDTH = $clog2(DEBOUNCE_CYCLES);

   logic [N_INPUTS-1:0] w_level;
   logic [N_INPUTS-1:0] w_rise;
   logic [N_INPUTS-1:0] w_fall;

   for (genvar g = 0; g < N_INPUTS; g++) begin : g_bit
      debounce_bit #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_WIDTH       (CNT_WIDTH)
      ) u_bit (
         .clk       (clk),
         .reset     (reset),
         .raw_in    (raw_in[g]),
         .level_out (w_level[g]),
         .rise_out  (w_rise[g]),
         .fall_out  (w_fall[g])
      );
   end

   assign level_out = w_level;
   assign rise_out  = w_rise;
   assign fall_out  = w_fall;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with a 4-cycle debounce window.
// Each step drives inputs, queues the expected outputs for that edge, then
// pops and compares them just after the edge.
module tb_input_conditioner;
   import cond_pkg::*;

   localparam int N = 4;
   localparam int D = SIM_DEBOUNCE_CYCLES;

`ifdef INPUT_CONDITIONER_FALL_EDGE_EN
   localparam logic [N-1:0] FMASK = '1;
`else
   localparam logic [N-1:0] FMASK = '0;
`endif

   typedef struct packed {
      logic [N-1:0] lvl;
      logic [N-1:0] rise;
      logic [N-1:0] fall;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [N-1:0] raw_in = '0;
   logic [N-1:0] level_out, rise_out, fall_out;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   input_conditioner #(.N_INPUTS(N), .DEBOUNCE_CYCLES(D)) dut (
      .clk       (clk),
      .reset     (reset),
      .raw_in    (raw_in),
      .level_out (level_out),
      .rise_out  (rise_out),
      .fall_out  (fall_out)
   );

   // One clock: drive, queue expectation, sample 1 time unit after the edge.
   task automatic step(input logic rst, input logic [N-1:0] raw,
                       input logic [N-1:0] lvl, input logic [N-1:0] rise,
                       input logic [N-1:0] fall, input string tag);
      exp_t e;
      reset  = rst;
      raw_in = raw;
      e.lvl  = lvl;
      e.rise = rise;
      e.fall = fall & FMASK;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      checks++;
      assert (level_out === e.lvl) else begin
         errors++;
         $error("FAIL %s level_out got %b exp %b", tag, level_out, e.lvl);
      end
      checks++;
      assert (rise_out === e.rise) else begin
         errors++;
         $error("FAIL %s rise_out got %b exp %b", tag, rise_out, e.rise);
      end
      checks++;
      assert (fall_out === e.fall) else begin
         errors++;
         $error("FAIL %s fall_out got %b exp %b", tag, fall_out, e.fall);
      end
   endtask

   // n quiet cycles: constant inputs, constant level, no pulses.
   task automatic hold(input logic rst, input logic [N-1:0] raw,
                       input logic [N-1:0] lvl, input int n, input string tag);
      for (int i = 0; i < n; i++) step(rst, raw, lvl, '0, '0, tag);
   endtask

   initial begin
      // Reset with all inputs high: outputs held at 0.
      hold(1'b1, 4'b1111, 4'b0000, 3, "reset_hold");
      // Level appears on the 6th edge after release, single rise pulse.
      hold(1'b0, 4'b1111, 4'b0000, 5, "post_reset_wait");
      step(1'b0, 4'b1111, 4'b1111, 4'b1111, 4'b0000, "post_reset_rise");
      hold(1'b0, 4'b1111, 4'b1111, 2, "post_reset_stable");

      // All inputs drop: falling pulses on the 6th edge (if enabled).
      hold(1'b0, 4'b0000, 4'b1111, 5, "all_fall_wait");
      step(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b1111, "all_fall_edge");
      hold(1'b0, 4'b0000, 4'b0000, 2, "all_fall_stable");

      // Clean step on bit 0.
      hold(1'b0, 4'b0001, 4'b0000, 5, "step0_wait");
      step(1'b0, 4'b0001, 4'b0001, 4'b0001, 4'b0000, "step0_rise");
      hold(1'b0, 4'b0001, 4'b0001, 2, "step0_stable");

      // Bounce on bit 1: 1,0,1,0 then hold 1 from the fifth cycle.
      step(1'b0, 4'b0011, 4'b0001, '0, '0, "bounce1");
      step(1'b0, 4'b0001, 4'b0001, '0, '0, "bounce2");
      step(1'b0, 4'b0011, 4'b0001, '0, '0, "bounce3");
      step(1'b0, 4'b0001, 4'b0001, '0, '0, "bounce4");
      hold(1'b0, 4'b0011, 4'b0001, 5, "bounce_hold");
      step(1'b0, 4'b0011, 4'b0011, 4'b0010, 4'b0000, "bounce_rise");
      hold(1'b0, 4'b0011, 4'b0011, 2, "bounce_stable");

      // Glitch on bit 2: three high cycles, one short of acceptance.
      hold(1'b0, 4'b0111, 4'b0011, 3, "glitch_high");
      hold(1'b0, 4'b0011, 4'b0011, 6, "glitch_low");

      // Reset with bit 2 pending at cnt=2: progress and levels discarded,
      // and no pulse of either polarity from the reset itself.
      hold(1'b0, 4'b0111, 4'b0011, 4, "pend_count");
      hold(1'b1, 4'b0111, 4'b0000, 2, "pend_reset");
      hold(1'b0, 4'b0111, 4'b0000, 5, "pend_full_latency");
      step(1'b0, 4'b0111, 4'b0111, 4'b0111, 4'b0000, "pend_rise");
      hold(1'b0, 4'b0111, 4'b0111, 1, "pend_stable");

      // Bit 3 up, then down: one fall pulse when enabled.
      hold(1'b0, 4'b1111, 4'b0111, 5, "b3_up_wait");
      step(1'b0, 4'b1111, 4'b1111, 4'b1000, 4'b0000, "b3_rise");
      hold(1'b0, 4'b1111, 4'b1111, 1, "b3_high");
      hold(1'b0, 4'b0111, 4'b1111, 5, "b3_down_wait");
      step(1'b0, 4'b0111, 4'b0111, 4'b0000, 4'b1000, "b3_fall");
      hold(1'b0, 4'b0111, 4'b0111, 2, "b3_low");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Conditions the raw Basys3 switch and pushbutton inputs before they reach the combinational LED logic stage.
- Per bit: 2-flop synchronizer, then counter-based debounce.
- Outputs per bit: a clean level, plus a single-cycle rising-edge pulse.
- Sits directly upstream of the gate/LED logic. Its debounced levels drive that stage's A, B, D and button inputs.

Parameters:
- N_INPUTS, 4, number of independent inputs conditioned (switches plus buttons).
- DEBOUNCE_CYCLES, 1000000, consecutive cycles a synchronized value must differ from the stable value before it is accepted (10 ms at 100 MHz). Legal range ≥2.
- CNT_WIDTH, $clog2(DEBOUNCE_CYCLES), derived width of each debounce counter. Not overridden by users.

Ports:
- clk  input  1  system clock, 100 MHz.
- reset  input  1  synchronous, active-high reset.
- raw_in  input  N_INPUTS  asynchronous switch/button pins.
- level_out  output  N_INPUTS  debounced stable level per input.
- rise_out  output  N_INPUTS  one-cycle pulse when the matching level_out goes 0→1.
- fall_out  output  N_INPUTS  one-cycle pulse when level_out goes 1→0. Constant 0 unless FALL_EDGE_EN is defined.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset), sampled only on the rising edge of clk.
- Reset values: sync flops 0, counters 0, level_out 0, rise_out 0, fall_out 0.
- Synchronizer: sync1 <= raw_in; sync2 <= sync1. No logic between the two flops.
- Per-bit debounce, evaluated each edge:
  - If sync2 == level_out: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: level_out <= sync2 and cnt <= 0.
  - Else: cnt <= cnt+1.
- Acceptance rule: a new value is accepted only after DEBOUNCE_CYCLES consecutive disagreeing cycles. Any single agreeing cycle (glitch or bounce back) restarts the count from 0.
- Latency: a clean raw_in step is first visible on level_out after 2 + DEBOUNCE_CYCLES rising edges.
- Edge pulses are registered:
  - rise_out[i] is high for exactly the one cycle in which level_out[i] has just become 1.
  - In the same cycle, level_out[i] shows the new value.
  - Never asserted for two consecutive cycles.
- Bits are fully independent. Simultaneous transitions on several bits produce simultaneous pulses.
- Counter never wraps: maximum value is DEBOUNCE_CYCLES-1, then it clears.
- Reset mid-count discards all progress.
  - No pulse is generated by reset itself.
  - An input held at 1 through reset gives level_out 0 right after reset, then rises (with a rise pulse) after 2 + DEBOUNCE_CYCLES edges.
- Reset has priority over all other updates.

Optional Feature:
- Macro: INPUT_CONDITIONER_FALL_EDGE_EN.
- Defined: fall_out[i] pulses for one cycle when level_out[i] transitions 1→0. Timing mirrors rise_out.
- Undefined: fall_out is tied to constant 0, and no falling-edge registers are synthesized.
- The port list is identical in both builds.

Decomposition:
- Shared package (cond_pkg):
  - DEFAULT_DEBOUNCE_CYCLES = 1000000.
  - SIM_DEBOUNCE_CYCLES = 4.
  - CLK_FREQ_HZ = 100000000.
- Sub-module: debounce_bit. It contains one bit's synchronizer, counter, level register and edge pulse logic.
- The top level instantiates debounce_bit N_INPUTS times with a generate loop and concatenates the outputs.

Test Plan (DEBOUNCE_CYCLES=4, N_INPUTS=4):
- Reset held 3 cycles with raw_in=4'b1111 → level_out, rise_out and fall_out stay 0 during reset. level_out becomes 4'b1111 on the 6th edge after reset release, with rise_out=4'b1111 for exactly that one cycle.
- Clean step raw_in[0] 0→1 → level_out[0]=1 after exactly 6 edges. rise_out[0] is a single-cycle pulse. Other bits are unchanged.
- Bounce: raw_in[1] toggles 1,0,1,0,1 on successive cycles, then holds 1 → no change while bouncing. level_out[1] rises 6 edges after the final hold begins, with exactly one rise pulse.
- Glitch: raw_in[2] high for 3 cycles, then low → level_out[2] stays 0 and no pulse occurs.
- Reset asserted when cnt=2 for a pending 0→1 → the counter clears and level_out stays 0. After release, full latency is required again.
- Falling edge, built with and without INPUT_CONDITIONER_FALL_EDGE_EN: level_out[3]=1, then raw_in[3]→0 → level_out[3]=0 after 6 edges.
  - Macro defined: one fall_out[3] pulse.
  - Macro undefined: fall_out remains 0 throughout.
